punc_mem_arbiter: RTL and testbench
===================================

Name: punc_mem_arbiter

Overview:
Sequences and shares the single memory port of the PUnC LC3 processor between two requesters: the CPU datapath (instruction fetch, LD/LDI/LDR/ST/STI/STR) and a debug/loader port. It uses fixed CPU priority with a starvation guard for the debug port. Reads take 2 cycles on a synchronous-read memory (1-cycle read latency); writes take 1 cycle. It sits between the PUnC datapath/controller and the memory block.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
STARVE_LIMIT, 4, consecutive CPU grants while debug waits before debug is forced a grant; legal range 1..15

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cpu_req  input  1  CPU access request; held until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_ack  output  1  one-cycle pulse: CPU request accepted this cycle
cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid
cpu_rdata  output  DATA_W  CPU read data
dbg_req  input  1  debug request; held until dbg_ack
dbg_we  input  1  debug write enable
dbg_addr  input  ADDR_W  debug address
dbg_wdata  input  DATA_W  debug write data
dbg_ack  output  1  one-cycle pulse: debug request accepted
dbg_rvalid  output  1  one-cycle pulse: dbg_rdata valid
dbg_rdata  output  DATA_W  debug read data
mem_addr  output  ADDR_W  memory address
mem_we  output  1  memory write enable
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid the cycle after address is presented

Behaviour:
- Reset (rst=1 at posedge): state <= IDLE, owner <= CPU, starve_cnt <= 0.
- While rst=1, all outputs are 0. No ack, rvalid or mem_we is asserted.
- A reset arriving during RD_WAIT aborts the read. No rvalid is issued.
- FSM states: IDLE, RD_WAIT.
- IDLE, arbitration is combinational each cycle:
  - Winner = DBG if dbg_req and (!cpu_req or starve_cnt == STARVE_LIMIT); else CPU if cpu_req; else none.
  - For the winner: mem_addr/mem_we/mem_wdata = winner's addr/we/wdata (wdata passed even on reads), and the winner's ack = 1 in the same cycle.
  - With no winner: mem_addr=0, mem_we=0, mem_wdata=0, both acks 0.
  - Winner write: stay in IDLE. The next arbitration happens the next cycle (back-to-back writes give 1 access per cycle).
  - Winner read: owner <= winner, go to RD_WAIT.
- RD_WAIT:
  - No ack. mem_we=0, mem_addr=0.
  - Owner's rvalid=1 and owner's rdata=mem_rdata. The non-owner's rdata=0.
  - Next state is IDLE. Read throughput is 1 per 2 cycles.
- rdata outputs are 0 whenever the matching rvalid is 0.
- Starvation counter (updated in IDLE only, held in RD_WAIT):
  - CPU granted while dbg_req=1: starve_cnt++ (saturating at STARVE_LIMIT).
  - DBG granted, or dbg_req=0: starve_cnt <= 0.
- Requester rules:
  - req is sampled only in IDLE.
  - After ack, the requester presents its next request (or drops req) on the following cycle.
  - A req dropped before ack is legal. Nothing is issued.
- Simultaneous cpu_req and dbg_req with starve_cnt < STARVE_LIMIT: CPU wins and DBG stays pending without ack.
- An address or data change while req is held without ack is legal. Only the values in the ack cycle are used.

Test Plan:
- Reset, then CPU read addr 0x3000 with mem returning 0xBEEF: cpu_ack at cycle 0, mem_addr=0x3000 at cycle 0, cpu_rvalid=1 and cpu_rdata=0xBEEF at cycle 1, dbg_rvalid stays 0.
- Debug writes 0x1234 to 0x0005, then 0xABCD to 0x0006 on consecutive cycles: dbg_ack and mem_we high in 2 consecutive cycles with the correct addr/wdata, and the state never leaves IDLE.
- cpu_req and dbg_req both held, all reads, STARVE_LIMIT=4: 4 CPU grants (every 2 cycles), then the 5th grant goes to debug, then starve_cnt=0 and the CPU resumes.
- CPU read granted, rst asserted in the RD_WAIT cycle: no cpu_rvalid, all outputs 0 during rst, and the first access after reset is granted normally.
- Both requests, all CPU writes, dbg_req held: debug granted on the 5th cycle. With dbg_req low throughout, starve_cnt stays 0 and there is no debug ack.
- Idle bus (no req): mem_we=0, mem_addr=0, no acks for 10 cycles.

Source files
------------

// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter: shares the single memory port between the CPU datapath and a debug/loader port.
// Latency: the grant and ack come in the same cycle as the request. Read data comes one cycle later. Writes finish in the ack cycle.
// Backpressure: the CPU has fixed priority. A debug request is forced through after STARVE_LIMIT CPU grants in a row. A losing requester holds req until it gets ack.
//
// Ports:
//   clk, rst                                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_ack/rvalid/rdata CPU requester
//   dbg_req/we/addr/wdata -> dbg_ack/rvalid/rdata debug/loader requester
//   mem_addr/we/wdata, mem_rdata                 synchronous-read memory (1-cycle read latency)
module punc_mem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {IDLE, RD_WAIT} state_t;

   state_t     state, state_nxt;
   logic       owner_dbg, owner_dbg_nxt;   // owner of the read that is in flight
   logic [3:0] starve_cnt, starve_nxt;     // CPU grants in a row while debug waits
   logic       cpu_win, dbg_win;

   // Arbitration is only meaningful in IDLE. The CPU wins unless the debug port has waited too long.
   always_comb begin
      dbg_win = dbg_req && (!cpu_req || (starve_cnt == LIMIT));
      cpu_win = cpu_req && !dbg_win;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner_dbg  <= 1'b0;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_nxt;
         owner_dbg  <= owner_dbg_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt     = state;
      owner_dbg_nxt = owner_dbg;
      starve_nxt    = starve_cnt;
      case (state)
         IDLE: begin
            // A write finishes in its ack cycle, so only a read leaves IDLE.
            if (dbg_win && !dbg_we) begin
               state_nxt     = RD_WAIT;
               owner_dbg_nxt = 1'b1;
            end else if (cpu_win && !cpu_we) begin
               state_nxt     = RD_WAIT;
               owner_dbg_nxt = 1'b0;
            end
            if (cpu_win && dbg_req)
               starve_nxt = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
            else
               starve_nxt = 4'd0;
         end
         RD_WAIT: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic. Reset forces every output low, even in the middle of a read.
   always_comb begin
      cpu_ack    = 1'b0;
      dbg_ack    = 1'b0;
      cpu_rvalid = 1'b0;
      dbg_rvalid = 1'b0;
      cpu_rdata  = '0;
      dbg_rdata  = '0;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (dbg_win) begin
                  dbg_ack   = 1'b1;
                  mem_addr  = dbg_addr;
                  mem_we    = dbg_we;
                  mem_wdata = dbg_wdata;
               end else if (cpu_win) begin
                  cpu_ack   = 1'b1;
                  mem_addr  = cpu_addr;
                  mem_we    = cpu_we;
                  mem_wdata = cpu_wdata;
               end
            end
            RD_WAIT: begin
               if (owner_dbg) begin
                  dbg_rvalid = 1'b1;
                  dbg_rdata  = mem_rdata;
               end else begin
                  cpu_rvalid = 1'b1;
                  cpu_rdata  = mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// tb_punc_mem_arbiter: random and directed stimulus for punc_mem_arbiter, checked against a transaction-level model.
// The model keeps a shadow copy of a 16-word memory and tracks the read in flight and the debug wait count.
// Inputs change 1 time unit after the rising edge. Outputs are compared on the falling edge.
module tb_punc_mem_arbiter;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic        cpu_ack, cpu_rvalid, dbg_ack, dbg_rvalid, mem_we;
   logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   function automatic logic [15:0] init_val(int i);
      return 16'hBEEF ^ 16'(i * 16'h1111);
   endfunction

   // Synchronous-read memory with 16 words, indexed by the low address bits.
   logic [15:0] mem [16];
   logic        mem_init;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      end else if (mem_we) begin
         mem[mem_addr[3:0]] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr[3:0]];
   end

   // Reference model state
   logic [15:0] shadow [16];
   int          busy;        // 0 = no read in flight, 1 = CPU read, 2 = debug read
   logic [15:0] rd_addr;
   int          starve;
   logic        last_cpu_ack, last_dbg_ack;
   // DUT values observed in the most recent step
   logic        obs_cpu_ack, obs_dbg_ack, obs_cpu_rvalid, obs_dbg_rvalid, obs_mem_we;
   logic [15:0] obs_cpu_rdata, obs_mem_addr;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Runs one clock cycle. It compares every output to the model, advances the model, and returns 1 unit after the next rising edge.
   task automatic step();
      logic [15:0] e_addr, e_wdata, e_crd, e_drd;
      logic        e_we, e_ca, e_da, e_cv, e_dv;
      bit          dw, cw;
      @(negedge clk);
      e_addr = '0; e_wdata = '0; e_crd = '0; e_drd = '0;
      e_we = 0; e_ca = 0; e_da = 0; e_cv = 0; e_dv = 0;
      if (!rst) begin
         if (busy != 0) begin
            e_cv = (busy == 1);
            e_dv = (busy == 2);
            if (e_cv) e_crd = shadow[rd_addr[3:0]];
            if (e_dv) e_drd = shadow[rd_addr[3:0]];
         end else begin
            dw = dbg_req && (!cpu_req || starve >= LIMIT);
            cw = cpu_req && !dw;
            if (dw) begin
               e_da = 1; e_addr = dbg_addr; e_we = dbg_we; e_wdata = dbg_wdata;
            end else if (cw) begin
               e_ca = 1; e_addr = cpu_addr; e_we = cpu_we; e_wdata = cpu_wdata;
            end
         end
      end
      check("cpu_ack",    16'(cpu_ack),    16'(e_ca));
      check("dbg_ack",    16'(dbg_ack),    16'(e_da));
      check("cpu_rvalid", 16'(cpu_rvalid), 16'(e_cv));
      check("dbg_rvalid", 16'(dbg_rvalid), 16'(e_dv));
      check("cpu_rdata",  cpu_rdata,       e_crd);
      check("dbg_rdata",  dbg_rdata,       e_drd);
      check("mem_addr",   mem_addr,        e_addr);
      check("mem_we",     16'(mem_we),     16'(e_we));
      check("mem_wdata",  mem_wdata,       e_wdata);
      obs_cpu_ack = cpu_ack; obs_dbg_ack = dbg_ack; obs_cpu_rvalid = cpu_rvalid;
      obs_dbg_rvalid = dbg_rvalid; obs_mem_we = mem_we; obs_cpu_rdata = cpu_rdata;
      obs_mem_addr = mem_addr;
      if (rst) begin
         busy = 0; starve = 0;
      end else if (busy != 0) begin
         busy = 0;
      end else begin
         if (e_ca || e_da) begin
            if (e_we) shadow[e_addr[3:0]] = e_wdata;
            else begin busy = e_da ? 2 : 1; rd_addr = e_addr; end
         end
         if (e_ca && dbg_req) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
         else starve = 0;
      end
      last_cpu_ack = e_ca; last_dbg_ack = e_da;
      @(posedge clk); #1;
   endtask

   initial begin
      int cpu_grants, cpu_before, dbg_cycle, cnt;
      bit dbg_done, resumed;
      rst = 1; mem_init = 1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
      busy = 0; starve = 0; rd_addr = '0; last_cpu_ack = 0; last_dbg_ack = 0;
      @(posedge clk); #1;
      step(); step();
      mem_init = 0; rst = 0;

      // CPU read of 0x3000 returns 0xBEEF one cycle after the ack.
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000; cpu_wdata = 16'h5555;
      step();
      check("t1_ack", 16'(obs_cpu_ack), 16'd1);
      check("t1_addr", obs_mem_addr, 16'h3000);
      cpu_req = 0;
      step();
      check("t1_rvalid", 16'(obs_cpu_rvalid), 16'd1);
      check("t1_rdata", obs_cpu_rdata, 16'hBEEF);
      check("t1_dbg_rvalid", 16'(obs_dbg_rvalid), 16'd0);

      // Two debug writes on back-to-back cycles, then a CPU read-back.
      dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0005; dbg_wdata = 16'h1234;
      step();
      check("t2_ack0", 16'(obs_dbg_ack & obs_mem_we), 16'd1);
      dbg_addr = 16'h0006; dbg_wdata = 16'hABCD;
      step();
      check("t2_ack1", 16'(obs_dbg_ack & obs_mem_we), 16'd1);
      dbg_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0006;
      step();
      cpu_req = 0;
      step();
      check("t2_readback", obs_cpu_rdata, 16'hABCD);

      // Both requesters issue reads. The debug port should get the grant after 4 CPU grants.
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0004;
      dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0007;
      cpu_grants = 0; cpu_before = 999; dbg_done = 0; resumed = 0;
      for (int i = 0; i < 30 && !resumed; i++) begin
         step();
         if (obs_cpu_ack) begin
            cpu_grants++;
            if (dbg_done) resumed = 1;
            cpu_addr = cpu_addr + 16'd1;
         end
         if (obs_dbg_ack) begin
            dbg_req = 0; dbg_done = 1; cpu_before = cpu_grants;
         end
      end
      check("starve_cpu_grants", 16'(cpu_before), 16'd4);
      check("starve_resume", 16'(resumed), 16'd1);
      cpu_req = 0;
      step();

      // Reset asserted in the RD_WAIT cycle cancels the read.
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0002;
      step();
      cpu_req = 0; rst = 1;
      step();
      check("rst_no_rvalid", 16'(obs_cpu_rvalid), 16'd0);
      rst = 0; cpu_req = 1; cpu_addr = 16'h0003;
      step();
      check("rst_after_ack", 16'(obs_cpu_ack), 16'd1);
      cpu_req = 0;
      step();
      check("rst_after_rdata", obs_cpu_rdata, shadow[3]);

      // CPU writes while a debug request is held. The debug grant should land on the 5th cycle.
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0008;
      dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0009; dbg_wdata = 16'h0909;
      dbg_cycle = 0;
      for (int c = 1; c <= 10; c++) begin
         cpu_wdata = 16'($urandom);
         step();
         if (obs_dbg_ack && dbg_cycle == 0) begin dbg_cycle = c; dbg_req = 0; end
      end
      check("wr_starve_cycle", 16'(dbg_cycle), 16'd5);
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         cpu_wdata = 16'($urandom);
         step();
         if (obs_dbg_ack) cnt++;
      end
      check("wr_no_dbg_ack", 16'(cnt), 16'd0);

      // Idle bus
      cpu_req = 0; dbg_req = 0; cnt = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (obs_cpu_ack || obs_dbg_ack || obs_mem_we || obs_mem_addr != 0) cnt++;
      end
      check("idle_quiet", 16'(cnt), 16'd0);

      // Random traffic with occasional resets, dropped requests, and address changes while a request waits.
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         if (last_cpu_ack || !cpu_req) begin
            cpu_req = ($urandom_range(0, 9) < 6);
            cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
         end else if ($urandom_range(0, 19) == 0) cpu_req = 0;
         else if ($urandom_range(0, 9) == 0) cpu_addr = 16'($urandom);
         if (last_dbg_ack || !dbg_req) begin
            dbg_req = ($urandom_range(0, 9) < 5);
            dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom);
         end else if ($urandom_range(0, 19) == 0) dbg_req = 0;
         else if ($urandom_range(0, 9) == 0) dbg_wdata = 16'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
